// File: rtl/rv32f_decode_issue_pkg.sv
// rv32f_decode_issue_pkg: RV32F op/encoding types and the combinational instruction decoder
package rv32f_decode_issue_pkg;
  typedef enum logic [4:0] {
    OP_FLW, OP_FSW, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD,
    OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT,
    OP_FSGNJ, OP_FSGNJN, OP_FSGNJX, OP_FMIN, OP_FMAX,
    OP_FCVT_W_S, OP_FCVT_WU_S, OP_FMV_X_W, OP_FEQ, OP_FLT, OP_FLE, OP_FCLASS,
    OP_FCVT_S_W, OP_FCVT_S_WU, OP_FMV_W_X, OP_ILLEGAL
  } rv32f_op_t;
  typedef enum logic [2:0] {
    RM_RNE = 3'b000, RM_RTZ = 3'b001, RM_RDN = 3'b010, RM_RUP = 3'b011,
    RM_RMM = 3'b100, RM_DYN = 3'b111
  } rv32f_rm_t;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] F7_FADD      = 7'b0000000;
  localparam logic [6:0] F7_FSUB      = 7'b0000100;
  localparam logic [6:0] F7_FMUL      = 7'b0001000;
  localparam logic [6:0] F7_FDIV      = 7'b0001100;
  localparam logic [6:0] F7_FSQRT     = 7'b0101100;
  localparam logic [6:0] F7_FSGNJ     = 7'b0010000;
  localparam logic [6:0] F7_FMINMAX   = 7'b0010100;
  localparam logic [6:0] F7_FCVT_W    = 7'b1100000;
  localparam logic [6:0] F7_FMV_X     = 7'b1110000;
  localparam logic [6:0] F7_FCMP      = 7'b1010000;
  localparam logic [6:0] F7_FCVT_S    = 7'b1101000;
  localparam logic [6:0] F7_FMV_W     = 7'b1111000;
  localparam logic [2:0] F3_WORD      = 3'b010;
  typedef struct packed {
    rv32f_op_t   op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  rm;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rs3;
    logic        fp_write;
    logic        int_write;
    logic        illegal;
  } rv32f_dec_t;

  function automatic rv32f_dec_t rv32f_decode(input logic [31:0] i);
    rv32f_dec_t d;
    logic [2:0] f3;
    logic [4:0] r2;
    logic rnd;
    logic bad;
    f3 = i[14:12];
    r2 = i[24:20];
    d = '0;
    d.rd = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = r2;
    d.rs3 = i[31:27];
    d.rm = f3;
    d.op = OP_ILLEGAL;
    rnd = 1'b0;
    bad = 1'b0;
    case (i[6:0])
      OPC_LOAD_FP: begin
        d.op = OP_FLW; d.imm = {{20{i[31]}}, i[31:20]}; d.fp_write = 1'b1; bad = f3 != F3_WORD;
      end
      OPC_STORE_FP: begin
        d.op = OP_FSW; d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; d.use_rs2 = 1'b1; bad = f3 != F3_WORD;
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        // opcode bits [3:2] select among the four fused ops in enum order
        d.op = rv32f_op_t'(OP_FMADD + 5'(i[3:2]));
        {d.use_rs1, d.use_rs2, d.use_rs3, d.fp_write, rnd} = 5'b11111;
        bad = i[26:25] != 2'b00;
      end
      OPC_OP_FP: case (i[31:25])
        F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV: begin
          d.op = rv32f_op_t'(OP_FADD + 5'(i[28:27]));
          {d.use_rs1, d.use_rs2, d.fp_write, rnd} = 4'b1111;
        end
        F7_FSQRT: begin
          d.op = OP_FSQRT; {d.use_rs1, d.fp_write, rnd} = 3'b111; bad = r2 != 5'd0;
        end
        F7_FSGNJ: begin
          d.op = rv32f_op_t'(OP_FSGNJ + 5'(f3[1:0])); {d.use_rs1, d.use_rs2, d.fp_write} = 3'b111; bad = f3 > 3'b010;
        end
        F7_FMINMAX: begin
          d.op = f3[0] ? OP_FMAX : OP_FMIN; {d.use_rs1, d.use_rs2, d.fp_write} = 3'b111; bad = f3 > 3'b001;
        end
        F7_FCVT_W: begin
          d.op = r2[0] ? OP_FCVT_WU_S : OP_FCVT_W_S; {d.use_rs1, d.int_write, rnd} = 3'b111; bad = r2 > 5'd1;
        end
        F7_FMV_X: begin
          d.op = f3[0] ? OP_FCLASS : OP_FMV_X_W; {d.use_rs1, d.int_write} = 2'b11;
          bad = f3 > 3'b001 || r2 != 5'd0;
        end
        F7_FCMP: begin
          d.op = f3 == 3'b010 ? OP_FEQ : f3 == 3'b001 ? OP_FLT : OP_FLE;
          {d.use_rs1, d.use_rs2, d.int_write} = 3'b111; bad = f3 > 3'b010;
        end
        F7_FCVT_S: begin
          d.op = r2[0] ? OP_FCVT_S_WU : OP_FCVT_S_W; {d.fp_write, rnd} = 2'b11; bad = r2 > 5'd1;
        end
        F7_FMV_W: begin
          d.op = OP_FMV_W_X; d.fp_write = 1'b1; bad = r2 != 5'd0;
        end
        default: bad = 1'b1;
      endcase
      default: bad = 1'b1;
    endcase
    if (rnd && (f3 == 3'b101 || f3 == 3'b110)) bad = 1'b1;
    if (bad) begin
      d.op = OP_ILLEGAL;
      d.imm = '0;
      {d.use_rs1, d.use_rs2, d.use_rs3, d.fp_write, d.int_write} = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction
endpackage

// File: rtl/rv32f_decode_issue_scoreboard.sv
// rv32f_decode_issue_scoreboard: pending-write mask over f0-f31 with RAW/WAW hazard lookup
module rv32f_decode_issue_scoreboard #(
  parameter bit SCOREBOARD_ENABLE = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        kill_en,
  input  logic [4:0]  kill_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rs3,
  input  logic [4:0]  rd,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic        use_rs3,
  input  logic        use_rd,
  output logic        hazard
);
  logic [31:0] pending, wb_mask, view;
  always_comb begin
    wb_mask = wb_valid ? 32'd1 << wb_rd : '0;
    view = WB_BYPASS ? pending & ~wb_mask : pending;
    hazard = SCOREBOARD_ENABLE &&
             ((use_rs1 && view[rs1]) || (use_rs2 && view[rs2]) ||
              (use_rs3 && view[rs3]) || (use_rd && view[rd]));
  end
  // clears apply first so a same-cycle set on the same register wins
  always_ff @(posedge clk)
    if (rst) pending <= '0;
    else pending <= (pending & ~wb_mask & ~(kill_en ? 32'd1 << kill_rd : '0)) |
                    (set_en ? 32'd1 << set_rd : '0);
endmodule

// File: rtl/rv32f_decode_issue.sv
// rv32f_decode_issue: RV32F decode/issue stage with hazard scoreboard and one-entry output register
module rv32f_decode_issue
  import rv32f_decode_issue_pkg::*;
#(
  parameter bit SCOREBOARD_ENABLE = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst_data,
  input  logic [31:0] inst_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_op,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rs3,
  output logic [2:0]  out_rm,
  output logic [31:0] out_imm,
  output logic [31:0] out_pc,
  output logic        out_fp_write,
  output logic        out_int_write,
  output logic        out_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush
);
  rv32f_dec_t dec;
  logic hazard, in_hs;
  assign dec = rv32f_decode(inst_data);
  assign inst_ready = !flush && (!out_valid || out_ready) && !hazard;
  assign in_hs = inst_valid && inst_ready;

  rv32f_decode_issue_scoreboard #(
    .SCOREBOARD_ENABLE(SCOREBOARD_ENABLE),
    .WB_BYPASS(WB_BYPASS)
  ) u_sb (
    .clk(clk),
    .rst(rst),
    .set_en(in_hs && dec.fp_write),
    .set_rd(dec.rd),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .kill_en(flush && out_valid && !out_ready && out_fp_write),
    .kill_rd(out_rd),
    .rs1(dec.rs1),
    .rs2(dec.rs2),
    .rs3(dec.rs3),
    .rd(dec.rd),
    .use_rs1(dec.use_rs1),
    .use_rs2(dec.use_rs2),
    .use_rs3(dec.use_rs3),
    .use_rd(dec.fp_write),
    .hazard(hazard)
  );

  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      {out_op, out_rd, out_rs1, out_rs2, out_rs3, out_rm} <= '0;
      {out_imm, out_pc, out_fp_write, out_int_write, out_illegal} <= '0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_op <= dec.op;
      out_rd <= dec.rd;
      out_rs1 <= dec.rs1;
      out_rs2 <= dec.rs2;
      out_rs3 <= dec.rs3;
      out_rm <= dec.rm;
      out_imm <= dec.imm;
      out_pc <= inst_pc;
      out_fp_write <= dec.fp_write;
      out_int_write <= dec.int_write;
      out_illegal <= dec.illegal;
    end else if (flush || out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_rv32f_decode_issue.sv
// tb_rv32f_decode_issue: decode vector table, hazard/flush/reset sequences and randomized scoreboard check
module tb_rv32f_decode_issue;
  import rv32f_decode_issue_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic inst_valid, inst_ready, out_valid, out_ready, flush, wb_valid;
  logic [31:0] inst_data, inst_pc, out_imm, out_pc;
  logic [4:0] out_op, out_rd, out_rs1, out_rs2, out_rs3, wb_rd;
  logic [2:0] out_rm;
  logic out_fp_write, out_int_write, out_illegal;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  rv32f_decode_issue dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_rm(out_rm), .out_imm(out_imm), .out_pc(out_pc), .out_fp_write(out_fp_write),
    .out_int_write(out_int_write), .out_illegal(out_illegal), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .flush(flush)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  op, rd, rs1, rs2, rs3;
    logic [2:0]  rm;
    logic [31:0] imm;
    logic        fpw, intw, ill;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(input logic [31:0] inst, input rv32f_op_t op,
                             input logic [4:0] rd, rs1, rs2, rs3, input logic [2:0] rm,
                             input logic [31:0] imm, input logic fpw, intw, ill);
    vec_t r;
    r.inst = inst; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.rs3 = rs3;
    r.rm = rm; r.imm = imm; r.fpw = fpw; r.intw = intw; r.ill = ill;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    inst_valid = 0; inst_data = 0; inst_pc = 0; out_ready = 1; flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic gen(output logic [31:0] ins, output logic [4:0] op, output logic [31:0] srcs,
                     output logic fpw, output logic [4:0] rd);
    logic [4:0] a, b, c, d;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    rd = a; fpw = 1; srcs = '0;
    case ($urandom_range(0, 5))
      0: begin ins = {7'h00, b, c, 3'b000, a, 7'h53}; op = OP_FADD; srcs = (32'd1 << b) | (32'd1 << c); end
      1: begin ins = {d, 2'b00, b, c, 3'b000, a, 7'h43}; op = OP_FMADD;
               srcs = (32'd1 << b) | (32'd1 << c) | (32'd1 << d); end
      2: begin ins = {12'($urandom), c, 3'b010, a, 7'h07}; op = OP_FLW; end
      3: begin ins = {7'($urandom), b, c, 3'b010, a, 7'h27}; op = OP_FSW; srcs = 32'd1 << b; fpw = 0; end
      4: begin ins = {7'h70, 5'd0, c, 3'b001, a, 7'h53}; op = OP_FCLASS; srcs = 32'd1 << c; fpw = 0; end
      default: begin ins = {7'h00, b, c, 3'b101, a, 7'h53}; op = OP_ILLEGAL; fpw = 0; end
    endcase
  endtask

  logic [31:0] ins, srcs, wbm, m_pend;
  logic [4:0] op, rd, m_rd, m_op;
  logic fpw, exp_rdy, acc, m_ov, m_fpw;

  initial begin
    vecs.push_back(v(32'h003100D3, OP_FADD, 1, 2, 3, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(32'h10508253, OP_FMUL, 4, 1, 5, 2, 0, 0, 1, 0, 0));
    vecs.push_back(v(32'hFFC52107, OP_FLW, 2, 10, 28, 31, 2, 32'hFFFFFFFC, 1, 0, 0));
    vecs.push_back(v(32'h003150D3, OP_ILLEGAL, 1, 2, 3, 0, 5, 0, 0, 0, 1));
    vecs.push_back(v(32'h003170D3, OP_FADD, 1, 2, 3, 0, 7, 0, 1, 0, 0));
    vecs.push_back(v(32'h0032A427, OP_FSW, 8, 5, 3, 0, 2, 8, 0, 0, 0));
    vecs.push_back(v(32'hA020A2D3, OP_FEQ, 5, 1, 2, 20, 2, 0, 0, 1, 0));
    vecs.push_back(v(32'hA020B2D3, OP_ILLEGAL, 5, 1, 2, 20, 3, 0, 0, 0, 1));
    vecs.push_back(v(32'h580100D3, OP_FSQRT, 1, 2, 0, 11, 0, 0, 1, 0, 0));
    vecs.push_back(v(32'h581100D3, OP_ILLEGAL, 1, 2, 1, 11, 0, 0, 0, 0, 1));
    vecs.push_back(v(32'hC00211D3, OP_FCVT_W_S, 3, 4, 0, 24, 1, 0, 0, 1, 0));
    vecs.push_back(v(32'hC01211D3, OP_FCVT_WU_S, 3, 4, 1, 24, 1, 0, 0, 1, 0));
    vecs.push_back(v(32'hC02211D3, OP_ILLEGAL, 3, 4, 2, 24, 1, 0, 0, 0, 1));
    vecs.push_back(v(32'h203100C3, OP_FMADD, 1, 2, 3, 4, 0, 0, 1, 0, 0));
    vecs.push_back(v(32'h223100C3, OP_ILLEGAL, 1, 2, 3, 4, 0, 0, 0, 0, 1));
    vecs.push_back(v(32'h00000013, OP_ILLEGAL, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(32'hF00483D3, OP_FMV_W_X, 7, 9, 0, 30, 0, 0, 1, 0, 0));
    vecs.push_back(v(32'hE00110D3, OP_FCLASS, 1, 2, 0, 28, 1, 0, 0, 1, 0));
    vecs.push_back(v(32'hE00100D3, OP_FMV_X_W, 1, 2, 0, 28, 0, 0, 0, 1, 0));

    do_reset();
    chk("reset_valid", out_valid, 0);
    chk("reset_pending", dut.u_sb.pending, 0);
    foreach (vecs[k]) begin
      do_reset();
      inst_valid = 1; inst_data = vecs[k].inst; inst_pc = 32'h1000 + 32'(k * 4);
      #1 chk($sformatf("vec%0d_ready", k), inst_ready, 1);
      tick();
      inst_valid = 0;
      chk($sformatf("vec%0d_out", k),
          {out_valid, out_op, out_rd, out_rs1, out_rs2, out_rs3, out_rm, out_imm, out_fp_write, out_int_write, out_illegal},
          {1'b1, vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].rs3, vecs[k].rm, vecs[k].imm,
           vecs[k].fpw, vecs[k].intw, vecs[k].ill});
      chk($sformatf("vec%0d_pc", k), out_pc, 32'h1000 + 32'(k * 4));
      chk($sformatf("vec%0d_pending", k), dut.u_sb.pending, vecs[k].fpw ? 32'd1 << vecs[k].rd : 32'd0);
    end

    // RAW stall on f1, released by a same-cycle writeback
    do_reset();
    inst_valid = 1; inst_data = 32'h003100D3;
    tick();
    inst_data = 32'h10508253;
    #1 chk("raw_stall", inst_ready, 0);
    tick();
    chk("raw_no_issue", out_valid, 0);
    wb_valid = 1; wb_rd = 1;
    #1 chk("bypass_ready", inst_ready, 1);
    tick();
    wb_valid = 0; inst_valid = 0;
    chk("bypass_out", {out_valid, out_op, out_rd}, {1'b1, OP_FMUL, 5'd4});
    chk("bypass_pending", dut.u_sb.pending, 32'h10);

    // writeback and new set on the same register: set wins; illegal never stalls
    do_reset();
    inst_valid = 1; inst_data = 32'h003100D3;
    tick();
    inst_data = 32'h00052087; wb_valid = 1; wb_rd = 1;
    #1 chk("waw_bypass_ready", inst_ready, 1);
    tick();
    wb_valid = 0;
    chk("set_wins", dut.u_sb.pending, 32'h2);
    inst_data = 32'h003150D3;
    #1 chk("illegal_no_stall", inst_ready, 1);
    tick();
    inst_valid = 0;
    chk("illegal_out", {out_valid, out_illegal, out_op}, {1'b1, 1'b1, OP_ILLEGAL});
    chk("illegal_pending", dut.u_sb.pending, 32'h2);

    // held output then flush
    do_reset();
    out_ready = 0; inst_valid = 1; inst_data = 32'h003100D3;
    tick();
    inst_data = 32'hF00483D3;
    #1 chk("hold_ready", inst_ready, 0);
    tick();
    chk("hold_out", {out_valid, out_op, out_rd}, {1'b1, OP_FADD, 5'd1});
    flush = 1;
    #1 chk("flush_blocks", inst_ready, 0);
    tick();
    flush = 0; inst_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_pending", dut.u_sb.pending, 0);

    // reset with live state
    do_reset();
    inst_valid = 1; inst_data = 32'h003100D3;
    tick();
    inst_data = 32'h00052207;
    tick();
    inst_valid = 0;
    chk("pre_rst_pending", dut.u_sb.pending, 32'h12);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_pending", dut.u_sb.pending, 0);
    chk("rst_fields", {out_op, out_rd, out_rs1, out_rs2, out_imm, out_fp_write}, 0);

    // randomized traffic against a set-based scoreboard model
    do_reset();
    m_pend = '0; m_ov = 0; m_rd = '0; m_op = '0; m_fpw = 0;
    for (int n = 0; n < 3000; n++) begin
      gen(ins, op, srcs, fpw, rd);
      inst_valid = $urandom_range(0, 3) != 0; inst_data = ins; inst_pc = $urandom;
      out_ready = $urandom_range(0, 3) != 0; flush = $urandom_range(0, 15) == 0;
      wb_valid = $urandom_range(0, 2) == 0; wb_rd = 5'($urandom_range(0, 7));
      wbm = wb_valid ? 32'd1 << wb_rd : '0;
      exp_rdy = !flush && (!m_ov || out_ready) && ((srcs | (fpw ? 32'd1 << rd : '0)) & m_pend & ~wbm) == '0;
      #1 chk("rnd_ready", inst_ready, exp_rdy);
      acc = inst_valid && exp_rdy;
      m_pend = (m_pend & ~wbm & ~((flush && m_ov && !out_ready && m_fpw) ? 32'd1 << m_rd : '0)) |
               ((acc && fpw) ? 32'd1 << rd : '0);
      if (acc) begin
        m_ov = 1; m_op = op; m_rd = rd; m_fpw = fpw;
      end else if (flush || out_ready) m_ov = 0;
      tick();
      chk("rnd_valid", out_valid, m_ov);
      if (m_ov) chk("rnd_out", {out_op, out_rd, out_fp_write}, {m_op, m_rd, m_fpw});
      chk("rnd_pending", dut.u_sb.pending, m_pend);
    end
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
